// File: rtl/reg_file_clr.sv
// ---------------------------------------------------------------------------
// reg_file_clr
//   Parametrised register file with hardware clear sequencing.
//   Two combinational read ports, one clocked write port. After reset, or on
//   a clear_req pulse, an internal sequencer zeroes one entry per cycle and
//   holds ready low until every entry has been cleared (DEPTH cycles).
//
// Parameters
//   DW       data width in bits
//   AW       address width, DEPTH = 2**AW entries
//   ZERO_R0  1: entry 0 always reads 0 and writes to address 0 are dropped
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   wr_en      write enable
//   wr_addr    write address
//   dat_in     write data
//   rd_addrA   read address, port A
//   rd_addrB   read address, port B
//   clear_req  single-cycle pulse, starts a full clear sequence
//   datA_out   read data, port A (0 while clearing)
//   datB_out   read data, port B (0 while clearing)
//   ready      high when the file is usable
//
// Optional feature
//   REG_FILE_CLR_BYPASS_EN: when defined, a write in an idle cycle is
//   forwarded to any read port addressing the same entry in that cycle.
// ---------------------------------------------------------------------------
module reg_file_clr #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    input  logic          clear_req,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic          ready
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          ready_reg, ready_next;

    logic [DW-1:0] core [DEPTH];

    logic          core_we;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;

    // Write address 0 is discarded in hardwired-zero mode.
    logic wr_blocked;
    assign wr_blocked = (ZERO_R0 != 0) && (wr_addr == '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
        end
    end

    // ---------------- next state and write port control ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_next = ready_reg;
        core_we    = 1'b0;
        core_waddr = wr_addr;
        core_wdata = dat_in;

        case (state_reg)
            CLEAR: begin
                // The sequencer owns the write port; external writes and
                // clear requests are ignored here.
                core_we    = 1'b1;
                core_waddr = cnt_reg;
                core_wdata = '0;
                cnt_next   = cnt_reg + AW'(1);   // wraps to 0 after DEPTH-1
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                end
            end
            default: begin
                if (clear_req) begin
                    // Clear wins over a simultaneous write.
                    state_next = CLEAR;
                    cnt_next   = '0;
                    ready_next = 1'b0;
                end else if (wr_en && !wr_blocked) begin
                    core_we = 1'b1;
                end
            end
        endcase

        // Entry contents are left untouched in the reset cycle itself.
        if (reset) begin
            core_we = 1'b0;
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (core_we) begin
            core[core_waddr] <= core_wdata;
        end
    end

    // ---------------- read ports ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic [DW-1:0] data;

            assign addr = (gi == 0) ? rd_addrA : rd_addrB;

            always_comb begin
                data = core[addr];
`ifdef REG_FILE_CLR_BYPASS_EN
                if (wr_en && !clear_req && (wr_addr == addr)) begin
                    data = dat_in;
                end
`endif
                // Forcing to zero last also suppresses forwarding while
                // clearing and for hardwired entry 0.
                if ((state_reg != IDLE) || ((ZERO_R0 != 0) && (addr == '0))) begin
                    data = '0;
                end
            end
        end
    endgenerate

    assign datA_out = g_rd[0].data;
    assign datB_out = g_rd[1].data;
    assign ready    = ready_reg;

endmodule

// File: tb/tb_reg_file_clr.sv
module tb_reg_file_clr;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] dat_in;
    logic [2:0] rd_addrA;
    logic [2:0] rd_addrB;
    logic       clear_req;
    logic [7:0] da, db, za, zb;
    logic       rdy, zrdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_clr #(.DW(8), .AW(3), .ZERO_R0(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .dat_in(dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .clear_req(clear_req), .datA_out(da), .datB_out(db), .ready(rdy)
    );

    reg_file_clr #(.DW(8), .AW(3), .ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .dat_in(dat_in), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .clear_req(clear_req), .datA_out(za), .datB_out(zb), .ready(zrdy)
    );

    typedef struct {
        logic       wr_en;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic cr);
        wr_en = we; wr_addr = wa; dat_in = wd;
        rd_addrA = ra; rd_addrB = rb; clear_req = cr;
    endtask

    initial begin
        logic [7:0] coll_exp;
`ifdef REG_FILE_CLR_BYPASS_EN
        coll_exp = 8'h22;
`else
        coll_exp = 8'h11;
`endif
        //          we    wa    wd     ra    rb    ea     eb
        vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd0, 3'd1, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 3'd7, 8'h3C, 3'd3, 3'd3, 8'hA5, 8'hA5};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA5, 8'h3C};
        vecs[3] = '{1'b1, 3'd2, 8'h11, 3'd4, 3'd5, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 3'd2, 8'h22, 3'd2, 3'd7, coll_exp, 8'h3C};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h22, 8'h22};
        vecs[6] = '{1'b1, 3'd0, 8'h5A, 3'd1, 3'd6, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 8'h5A, 8'hA5};

        // ---------------- reset and initial clear ----------------
        reset = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            drive(1'b1, 3'(i - 1), 8'hEE, 3'(i - 1), 3'(i - 1), 1'b0);
            #1;
            $display("reset cycle %0d: ready=%0b a=%h b=%h", i, rdy, da, db);
            chk($sformatf("rst_ready_c%0d", i), {7'd0, rdy}, 8'h00);
            chk($sformatf("rst_zready_c%0d", i), {7'd0, zrdy}, 8'h00);
            chk($sformatf("rst_datA_c%0d", i), da, 8'h00);
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        #1;
        $display("reset cycle 9: ready=%0b", rdy);
        chk("rst_ready_c9", {7'd0, rdy}, 8'h01);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(a), 3'(7 - a), 1'b0);
            #1;
            $display("post-reset read %0d: a=%h b=%h", a, da, db);
            chk($sformatf("rst_zeroA_%0d", a), da, 8'h00);
            chk($sformatf("rst_zeroB_%0d", a), db, 8'h00);
        end

        // ---------------- table-driven write/read vectors ----------------
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            drive(vecs[v].wr_en, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb, 1'b0);
            #1;
            $display("vec %0d: we=%0b wa=%0d wd=%h ra=%0d rb=%0d -> a=%h b=%h",
                     v, vecs[v].wr_en, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb, da, db);
            chk($sformatf("vec%0d_datA", v), da, vecs[v].ea);
            chk($sformatf("vec%0d_datB", v), db, vecs[v].eb);
            chk($sformatf("vec%0d_ready", v), {7'd0, rdy}, 8'h01);
        end

        // ---------------- hardwired zero entry ----------------
        @(negedge clk);
        drive(1'b1, 3'd1, 8'h66, 3'd0, 3'd0, 1'b0);
        #1;
        $display("zero_r0 write cycle: za=%h zb=%h", za, zb);
        chk("z_r0_during_write", za, 8'h00);
        @(negedge clk);
        drive(1'b1, 3'd0, 8'h5A, 3'd0, 3'd0, 1'b0);
        #1;
        chk("z_r0_bypass_suppressed", zb, 8'h00);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 1'b0);
        #1;
        $display("zero_r0 read: za=%h zb=%h a=%h b=%h", za, zb, da, db);
        chk("z_r0_readA", za, 8'h00);
        chk("z_r1_readB", zb, 8'h66);
        chk("n_r0_readA", da, 8'h5A);
        chk("n_r1_readB", db, 8'h66);

        // ---------------- clear request with competing write ----------------
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            drive(1'b1, 3'(a), 8'hFF, 3'd0, 3'd0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 3'd5, 8'h77, 3'd5, 3'd4, 1'b1);
        #1;
        $display("clear_req cycle: a=%h b=%h ready=%0b", da, db, rdy);
        chk("clr_req_cycle_datA", da, 8'hFF);
        chk("clr_req_cycle_datB", db, 8'hFF);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            // A stray clear_req in the 3rd clear cycle must not extend it.
            drive(1'b1, 3'd5, 8'h77, 3'd5, 3'(i - 1), (i == 3));
            #1;
            $display("clear cycle %0d: ready=%0b a=%h b=%h", i, rdy, da, db);
            chk($sformatf("clr_ready_c%0d", i), {7'd0, rdy}, 8'h00);
            chk($sformatf("clr_datA_c%0d", i), da, 8'h00);
            chk($sformatf("clr_datB_c%0d", i), db, 8'h00);
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd6, 1'b0);
        #1;
        $display("clear done: ready=%0b a=%h b=%h", rdy, da, db);
        chk("clr_ready_after", {7'd0, rdy}, 8'h01);
        chk("clr_addr5_after", da, 8'h00);
        chk("clr_addr6_after", db, 8'h00);

        // ---------------- reset in the middle of a clear ----------------
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
            #1;
            chk($sformatf("midclr_ready_c%0d", i), {7'd0, rdy}, 8'h00);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            $display("post-reset clear cycle %0d: ready=%0b", i, rdy);
            chk($sformatf("midrst_ready_c%0d", i), {7'd0, rdy}, 8'h00);
        end
        @(negedge clk);
        #1;
        $display("post-reset clear done: ready=%0b", rdy);
        chk("midrst_ready_c9", {7'd0, rdy}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_clr.md
Name: reg_file_clr

Overview:
- Parametrised successor to the processor's 8-bit register file: configurable data width and depth, two combinational read ports, one clocked write port.
- Adds hardware clear sequencing. After reset, or on request, an internal FSM zeroes one entry per cycle and holds `ready` low until every entry is clean.
- Optional optional r0-hardwired-zero mode.
- Sits in the processor datapath between decode (read addresses) and writeback (write port). The control unit stalls on `!ready`.

Parameters:
- DW, 8, data width in bits.
- AW, 3, address width; DEPTH = 2**AW entries.
- ZERO_R0, 0, when 1: entry 0 always reads 0 and writes to address 0 are discarded.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- dat_in  in  DW  write data.
- rd_addrA  in  AW  read address, port A.
- rd_addrB  in  AW  read address, port B.
- clear_req  in  1  single-cycle pulse; starts a full clear sequence.
- datA_out  out  DW  read data, port A.
- datB_out  out  DW  read data, port B.
- ready  out  1  high when the file is usable (FSM in IDLE).

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). No other reset.
- FSM has two states, IDLE and CLEAR, plus a clear counter cnt[AW-1:0].
- Reset, sampled high at a posedge: state <= CLEAR, cnt <= 0, ready <= 0. Entry contents are not touched in the reset cycle itself. `ready` therefore reads 0 in the cycle after any reset edge.
- CLEAR state, each cycle:
  - core[cnt] <= 0 and cnt <= cnt+1.
  - At cnt == DEPTH-1: core[DEPTH-1] <= 0, state <= IDLE, ready <= 1, cnt <= 0.
  - A clear takes exactly DEPTH cycles. With the default, `ready` rises 8 cycles after the first CLEAR cycle.
- CLEAR state, external inputs:
  - wr_en is ignored; the write is dropped, not queued.
  - datA_out and datB_out are forced to 0.
  - clear_req is ignored; it neither restarts nor extends the sequence.
- IDLE state, reads:
  - Combinational: datX_out = core[rd_addrX].
  - Both ports may read the same address.
- IDLE state, writes:
  - If wr_en, core[wr_addr] <= dat_in at the posedge.
  - A read in the same cycle as a write to that address returns the old value (no bypass, unless the optional feature is enabled).
- IDLE state, clear_req: if clear_req is high, state <= CLEAR, cnt <= 0, ready <= 0.
- Simultaneous events:
  - clear_req and wr_en in the same IDLE cycle: the clear wins and the write is discarded.
  - reset has priority over everything.
  - reset asserted mid-CLEAR restarts the sequence from cnt = 0.
- ZERO_R0 = 1:
  - Any read of address 0 returns 0 in all states.
  - wr_en with wr_addr == 0 leaves core[0] unchanged.
  - The clear sequence still steps through address 0, so timing is unchanged.
- Widths:
  - cnt wraps naturally at DEPTH.
  - No arithmetic on the data path; dat_in is stored unmodified at DW bits.
- Reset values of outputs:
  - ready = 0.
  - datA_out = datB_out = 0, held at 0 until ready = 1.

Optional Feature:
- Macro: REG_FILE_CLR_BYPASS_EN.
- Defined: in IDLE, if wr_en is high and wr_addr == rd_addrX, datX_out = dat_in in the same cycle (write-to-read forwarding).
  - Bypass is suppressed when ZERO_R0 = 1 and the address is 0.
  - Bypass is suppressed in CLEAR.
  - Bypass is suppressed when clear_req is high in that cycle.
- Undefined: reads always return stored contents (old value on same-cycle collision).

Test Plan:
- Reset and clear timing: reset high 1 cycle, then low. Required: ready = 0 for 8 cycles, ready = 1 on the 9th cycle. All 8 addresses then read 0x00 on both ports.
- Write then read:
  - Write 0xA5 to addr 3, then 0x3C to addr 7.
  - Next cycle, rd_addrA = 3 and rd_addrB = 7: datA_out = 0xA5, datB_out = 0x3C.
  - rd_addrA = rd_addrB = 3: both ports read 0xA5.
- Same-cycle collision:
  - Addr 2 holds 0x11. Write 0x22 to addr 2 while rd_addrA = 2.
  - Without the macro: 0x11 that cycle, 0x22 the next cycle.
  - With REG_FILE_CLR_BYPASS_EN: 0x22 immediately.
- Clear request with competing write:
  - Fill entries with 0xFF. Pulse clear_req together with wr_en (addr 5, 0x77).
  - Required: ready = 0 for 8 cycles. All reads return 0 during that time. Addr 5 reads 0x00 afterwards.
  - wr_en during CLEAR is dropped.
- Reset mid-clear: assert reset on the 4th CLEAR cycle. Required: ready rises exactly 8 cycles after reset deasserts, not 4.
- ZERO_R0 = 1: write 0x5A to addr 0 and read addr 0 on both ports. Required: always 0x00; other addresses unaffected.
